// File: rtl/nand_logic_pipe.sv
// nand_logic_pipe: WIDTH-bit bitwise logic unit (NAND/AND/NOR/XOR) feeding a
// STAGES-deep valid/ready register pipeline with full back-pressure.
// Optional feature macro: NAND_PIPE_COUNT_EN adds the 16-bit xfer_cnt output
// counting delivered results (wraps at 16'hFFFF).
module nand_logic_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef NAND_PIPE_COUNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_AND  = 2'b01,
        OP_NOR  = 2'b10,
        OP_XOR  = 2'b11
    } op_e;

    op_e              op_sel;
    logic [WIDTH-1:0] res_d;
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0] d_q [STAGES];
    logic [STAGES-1:0] rdy;
    logic             rdy_acc;

    assign op_sel = op_e'(op);

    // Bitwise operation selected by op, evaluated on the current operands
    always_comb begin
        res_d = '0;
        case (op_sel)
            OP_NAND: res_d = ~(a & b);
            OP_AND:  res_d = a & b;
            OP_NOR:  res_d = ~(a | b);
            OP_XOR:  res_d = a ^ b;
            default: res_d = '0;
        endcase
    end

    // Ready chain: stage k can load when it or any stage downstream is empty,
    // or when the consumer takes the last stage. Accumulated in a scalar from
    // the output end so no vector bit depends on another bit of itself.
    always_comb begin
        rdy_acc = out_ready;
        rdy     = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy_acc            = rdy_acc | ~v_q[STAGES-1-i];
            rdy[STAGES-1-i]    = rdy_acc;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign y         = d_q[STAGES-1];

    // Pipeline registers: stage 0 captures the result, later stages shift forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    d_q[0] <= res_d;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
        end
    end

`ifdef NAND_PIPE_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: one more per output transfer, natural 16-bit wrap
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Delivered-result counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nand_logic_pipe.sv
// Testbench for nand_logic_pipe: directed vectors plus a random scoreboard run.
// The xfer_cnt checks are built only when NAND_PIPE_COUNT_EN is defined.
module tb_nand_logic_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Main instance, WIDTH=8 STAGES=2
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;

    // Single-bit instance, WIDTH=1 STAGES=1
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic [1:0] op1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic       y1;

`ifdef NAND_PIPE_COUNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nand_logic_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef NAND_PIPE_COUNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    nand_logic_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1),
        .out_valid(out_valid1), .out_ready(out_ready1), .y(y1)
`ifdef NAND_PIPE_COUNT_EN
        , .xfer_cnt(xfer_cnt1)
`endif
    );

    // Independent reference: per-bit truth table indexed by {op, a_i, b_i}
    function automatic logic [7:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic [1:0] rop);
        logic [15:0] tt;
        logic [3:0]  idx;
        logic [7:0]  r;
        tt = 16'h6187;
        r  = '0;
        for (int i = 0; i < 8; i++) begin
            idx  = {rop, ra[i], rb[i]};
            r[i] = tt[idx];
        end
        return r;
    endfunction

    // Drive one cycle on the main instance; report what transfers on the coming edge
    task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [1:0] iop, input logic ordy,
                        output logic acc, output logic del, output logic [7:0] yo);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        yo  = y;
    endtask

    task automatic test_reset();
        logic acc, del;
        logic [7:0] yo;
        int ndel;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", y); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hF0, 8'hCC, 2'b00, 1'b0, acc, del, yo);
        step(1'b1, 8'hAA, 8'h55, 2'b11, 1'b0, acc, del, yo);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midflight_loaded got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL midrst_y got=%h exp=00", y); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        ndel = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, acc, del, yo);
            if (del) ndel++;
        end
        n_checks++; if (ndel !== 0) begin n_fail++; $display("FAIL midrst_no_delivery got=%0d exp=0", ndel); end
    endtask

    task automatic test_truth_table();
        logic [1:0] ops [4];
        logic [7:0] exp_y [4];
        int del_step [4];
        logic [7:0] del_val [4];
        int nacc, ndel;
        logic acc, del;
        logic [7:0] yo;
        ops[0] = 2'b00; exp_y[0] = 8'h3F;
        ops[1] = 2'b01; exp_y[1] = 8'hC0;
        ops[2] = 2'b10; exp_y[2] = 8'h03;
        ops[3] = 2'b11; exp_y[3] = 8'h3C;
        nacc = 0; ndel = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 8'hF0, 8'hCC, ops[i % 4], 1'b1, acc, del, yo);
            if (acc) nacc++;
            if (del) begin
                if (ndel < 4) begin
                    del_step[ndel] = i;
                    del_val[ndel]  = yo;
                end
                ndel++;
            end
        end
        n_checks++; if (nacc !== 4) begin n_fail++; $display("FAIL tt_accepts got=%0d exp=4", nacc); end
        n_checks++; if (ndel !== 4) begin n_fail++; $display("FAIL tt_deliveries got=%0d exp=4", ndel); end
        for (int j = 0; j < 4 && j < ndel; j++) begin
            n_checks++; if (del_val[j] !== exp_y[j]) begin n_fail++; $display("FAIL tt_value[%0d] got=%h exp=%h", j, del_val[j], exp_y[j]); end
            n_checks++; if (del_step[j] !== j + 2) begin n_fail++; $display("FAIL tt_latency[%0d] got=%0d exp=%0d", j, del_step[j], j + 2); end
        end
    endtask

    task automatic test_one_bit();
        logic exp_y [4];
        logic got;
        logic vld;
        exp_y[0] = 1'b1; exp_y[1] = 1'b1; exp_y[2] = 1'b1; exp_y[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            op1 = 2'b00;
            a1 = (i >= 2);
            b1 = (i % 2 == 1);
            #1;
            n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL bit_in_ready[%0d] got=%b exp=1", i, in_ready1); end
            @(negedge clk);
            in_valid1 = 1'b0;
            #1;
            vld = out_valid1;
            got = y1;
            n_checks++; if (vld !== 1'b1 || got !== exp_y[i]) begin n_fail++; $display("FAIL bit_nand[%0d] got=%b/%b exp=1/%b", i, vld, got, exp_y[i]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [1:0] vo [3];
        logic [7:0] exp_y [3];
        logic [7:0] got [3];
        int nacc, ndel;
        logic acc, del;
        logic [7:0] yo;
        va[0] = 8'hF0; vb[0] = 8'hCC; vo[0] = 2'b00; exp_y[0] = 8'h3F;
        va[1] = 8'h12; vb[1] = 8'h34; vo[1] = 2'b01; exp_y[1] = 8'h10;
        va[2] = 8'h0F; vb[2] = 8'h3C; vo[2] = 2'b11; exp_y[2] = 8'h33;
        nacc = 0; ndel = 0;
        for (int i = 0; i < 12; i++) begin
            step(nacc < 3, va[nacc % 3], vb[nacc % 3], vo[nacc % 3], i >= 5, acc, del, yo);
            if (i >= 2 && i <= 4) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
                n_checks++; if (out_valid !== 1'b1 || yo !== 8'h3F) begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/3f", i, out_valid, yo); end
            end
            if (i == 4) begin
                n_checks++; if (nacc !== 2) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=2", nacc); end
            end
            if (acc) nacc++;
            if (del) begin
                if (ndel < 3) got[ndel] = yo;
                ndel++;
            end
        end
        n_checks++; if (ndel !== 3) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=3", ndel); end
        for (int j = 0; j < 3 && j < ndel; j++) begin
            n_checks++; if (got[j] !== exp_y[j]) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", j, got[j], exp_y[j]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] ra, rb, exp_v;
        logic [1:0] rop;
        logic acc, del;
        logic [7:0] yo;
        int ndel, nfull;
        ndel = 0; nfull = 0;
        for (int i = 0; i < 1020; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom);
            step(i < 1000 && ($urandom_range(0, 3) != 0), ra, rb, rop,
                 (i >= 1000) || ($urandom_range(0, 2) != 0), acc, del, yo);
            if (acc && del && out_valid && dut.v_q[0]) nfull++;
            if (del) begin
                ndel++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected got=%h exp=none", yo);
                end else begin
                    exp_v = q.pop_front();
                    if (yo !== exp_v) begin n_fail++; $display("FAIL rand_data got=%h exp=%h", yo, exp_v); end
                end
            end
            if (acc) q.push_back(ref_op(ra, rb, rop));
        end
        n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL rand_lost got=%0d exp=0 pending", q.size()); end
        n_checks++; if (nfull == 0) begin n_fail++; $display("FAIL rand_full_pipe_overlap got=%0d exp=>0", nfull); end
    endtask

`ifdef NAND_PIPE_COUNT_EN
    task automatic test_count();
        logic acc, del;
        logic [7:0] yo;
        int nacc, ndel;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        nacc = 0; ndel = 0;
        for (int i = 0; i < 65600 && ndel < 65537; i++) begin
            step(nacc < 65537, 8'h00, 8'h00, 2'b00, 1'b1, acc, del, yo);
            if (acc) nacc++;
            if (del) ndel++;
        end
        step(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, acc, del, yo);
        n_checks++; if (ndel !== 65537) begin n_fail++; $display("FAIL cnt_transfers got=%0d exp=65537", ndel); end
        n_checks++; if (xfer_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=1", xfer_cnt); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_reset got=%0d exp=0", xfer_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_one_bit();
        test_back_pressure();
        test_random();
`ifdef NAND_PIPE_COUNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
